// File: rtl/shifter_pkg.sv
// shifter_pkg: shared types for the iterative shifter.
// ITER_SHIFTER_ROT_EN adds ROL/ROR to the supported mode set.
package shifter_pkg;
  localparam int SHAMT_W = 5;
  typedef enum logic [2:0] {
    M_LSL = 3'b000,
    M_LSR = 3'b001,
    M_ASR = 3'b010,
    M_ROL = 3'b011,
    M_ROR = 3'b100
  } shift_mode_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} iter_state_t;
  function automatic logic mode_ok(input logic [2:0] m);
`ifdef ITER_SHIFTER_ROT_EN
    return m <= 3'd4;
`else
    return m <= 3'd2;
`endif
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit combinational shift/rotate step; ITER_SHIFTER_ROT_EN enables ROL/ROR.
module shift_step
  import shifter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] r,
  input  shift_mode_t  mode,
  input  logic         sin,
  output logic [W-1:0] nr,
  output logic         ob
);
  always_comb begin
    nr = r;
    ob = 1'b0;
    case (mode)
      M_LSL: {ob, nr} = {r, sin};
      M_LSR: {nr, ob} = {sin, r};
      M_ASR: {nr, ob} = {r[W-1], r};
`ifdef ITER_SHIFTER_ROT_EN
      M_ROL: {ob, nr} = {r, r[W-1]};
      M_ROR: {nr, ob} = {r[0], r};
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter doing one bit per clock.
// ITER_SHIFTER_ROT_EN enables ROL/ROR; otherwise they complete as no-ops.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [SHAMT_W-1:0]   nbits,
  input  logic [2:0]           mode,
  input  logic                 sin,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result,
  output logic                 sout
);
  iter_state_t state, state_nx;
  logic [SHAMT_W-1:0] cnt;
  shift_mode_t mode_q;
  logic sin_q;
  logic [REG_WIDTH-1:0] r_nx;
  logic ob;
  logic accept;
  assign accept = start && state != SHIFT;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  shift_step #(.W(REG_WIDTH)) u_step (
    .r    (result),
    .mode (mode_q),
    .sin  (sin_q),
    .nr   (r_nx),
    .ob   (ob)
  );
  // Unsupported modes and zero shifts skip SHIFT and finish next cycle.
  always_comb begin
    state_nx = accept ? ((|nbits && mode_ok(mode)) ? SHIFT : DONE)
             : state == SHIFT ? (cnt == SHAMT_W'(1) ? DONE : SHIFT)
             : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= M_LSL;
      sin_q  <= 1'b0;
      result <= '0;
      sout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= nbits;
        mode_q <= shift_mode_t'(mode);
        sin_q  <= sin;
        result <= op_a;
        sout   <= 1'b0;
      end else if (state == SHIFT) begin
        cnt    <= cnt - SHAMT_W'(1);
        result <= r_nx;
        sout   <= ob;
      end
    end
  end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed vectors plus multi-cycle corner sequences for iter_shifter.
module tb_iter_shifter;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sin = 1'b0;
  logic [31:0] op_a = '0;
  logic [4:0] nbits = '0;
  logic [2:0] mode = '0;
  logic busy, done, sout;
  logic [31:0] result;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] op_a;
    logic [4:0]  nbits;
    logic [2:0]  mode;
    logic        sin;
    logic [31:0] exp_r;
    logic        exp_s;
    int          exp_lat;
  } vec_t;
  vec_t v[$];

  iter_shifter #(.REG_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .nbits(nbits),
    .mode(mode), .sin(sin), .busy(busy), .done(done), .result(result), .sout(sout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [31:0] a, logic [4:0] n, logic [2:0] m, logic s,
                              logic [31:0] er, logic es, int el);
    vec_t t;
    t.op_a = a; t.nbits = n; t.mode = m; t.sin = s;
    t.exp_r = er; t.exp_s = es; t.exp_lat = el;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic launch(input vec_t t);
    op_a = t.op_a; nbits = t.nbits; mode = t.mode; sin = t.sin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc = 0;
    while (!done && lat < 40) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t t, input string name);
    int lat, bc;
    launch(t);
    wait_done(1, lat, bc);
    chk({name, " latency"}, lat, t.exp_lat);
    chk({name, " result"}, result, t.exp_r);
    chk({name, " sout"}, {31'b0, sout}, {31'b0, t.exp_s});
    chk({name, " busy cycles"}, bc, t.exp_lat - 1);
    @(negedge clk);
    chk({name, " done pulse width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat, bc;
    v.push_back(mk(32'h8000_0001, 5'd1,  3'b000, 1'b0, 32'h0000_0002, 1'b1, 2));
    v.push_back(mk(32'h8000_0000, 5'd4,  3'b010, 1'b0, 32'hF800_0000, 1'b0, 5));
    v.push_back(mk(32'h1234_5678, 5'd0,  3'b001, 1'b0, 32'h1234_5678, 1'b0, 1));
    v.push_back(mk(32'hFFFF_FFFF, 5'd8,  3'b001, 1'b0, 32'h00FF_FFFF, 1'b1, 9));
    v.push_back(mk(32'h0000_000F, 5'd4,  3'b000, 1'b1, 32'h0000_00FF, 1'b0, 5));
    v.push_back(mk(32'h0000_00F0, 5'd5,  3'b001, 1'b1, 32'hF800_0007, 1'b1, 6));
    v.push_back(mk(32'h7FFF_FFFF, 5'd31, 3'b010, 1'b0, 32'h0000_0000, 1'b1, 32));
    v.push_back(mk(32'h0000_0001, 5'd31, 3'b000, 1'b0, 32'h8000_0000, 1'b0, 32));
    v.push_back(mk(32'h8000_0000, 5'd31, 3'b001, 1'b0, 32'h0000_0001, 1'b0, 32));
    v.push_back(mk(32'hDEAD_BEEF, 5'd7,  3'b101, 1'b0, 32'hDEAD_BEEF, 1'b0, 1));
    v.push_back(mk(32'hABCD_0123, 5'd0,  3'b111, 1'b1, 32'hABCD_0123, 1'b0, 1));
`ifdef ITER_SHIFTER_ROT_EN
    v.push_back(mk(32'h0000_0001, 5'd1,  3'b100, 1'b0, 32'h8000_0000, 1'b1, 2));
    v.push_back(mk(32'h8000_0003, 5'd2,  3'b011, 1'b0, 32'h0000_000E, 1'b0, 3));
`else
    v.push_back(mk(32'h0000_0001, 5'd1,  3'b100, 1'b0, 32'h0000_0001, 1'b0, 1));
    v.push_back(mk(32'h8000_0003, 5'd2,  3'b011, 1'b0, 32'h8000_0003, 1'b0, 1));
`endif

    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, sout, 29'b0} | result, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) run_vec(v[i], $sformatf("vec%0d", i));

    // A start while shifting must be ignored.
    launch(mk(32'hFFFF_FFFF, 5'd8, 3'b001, 1'b0, 0, 0, 0));
    @(negedge clk);
    op_a = 32'h0; nbits = 5'd1; mode = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bc);
    chk("busy-start latency", lat, 9);
    chk("busy-start result", result, 32'h00FF_FFFF);
    chk("busy-start sout", {31'b0, sout}, 32'd1);

    // Start sampled in DONE begins a new operation immediately.
    launch(mk(32'h0000_0003, 5'd2, 3'b000, 1'b0, 0, 0, 0));
    wait_done(1, lat, bc);
    chk("b2b first latency", lat, 3);
    chk("b2b first result", result, 32'h0000_000C);
    launch(mk(32'h0000_00F0, 5'd4, 3'b001, 1'b0, 0, 0, 0));
    chk("b2b second busy", {31'b0, busy}, 32'd1);
    wait_done(1, lat, bc);
    chk("b2b second latency", lat, 5);
    chk("b2b second result", result, 32'h0000_000F);
    chk("b2b second sout", {31'b0, sout}, 32'd0);

    // Reset mid-shift aborts with no done, then the next start works.
    launch(mk(32'hFFFF_FFFF, 5'd10, 3'b000, 1'b0, 0, 0, 0));
    @(negedge clk);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset result", result, 32'd0);
    chk("async reset flags", {29'b0, busy, done, sout}, 32'd0);
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      bc += int'(done) + int'(busy);
    end
    chk("no done during reset", bc, 0);
    rst_n = 1'b1;
    run_vec(v[0], "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
